// File: rtl/bcd2bin_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter: request side
// (start, packed BCD) and result side (binary value, status flags).
interface bcd2bin_seq_if #(
  parameter int DIGITS = 3,
  parameter int BW     = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BW-1:0]         bin_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  bin_out, busy, done, err
  );

  modport slave (
    input  start, bcd_in,
    output bin_out, busy, done, err
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double-dabble:
// one bit per cycle moves from the BCD work register into the binary accumulator.
module bcd2bin_seq #(
  parameter int DIGITS = 3,
  parameter int BW     = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd2bin_seq_if.slave  bus
);

  localparam int WW = 4 * DIGITS;
  localparam int CW = $clog2(BW + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [WW-1:0]   work_q;
  logic [BW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   bin_out_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic [WW+BW-1:0] shift_d;
  logic [WW-1:0]    work_d;
  logic [BW-1:0]    acc_d;

  // Digits that reached 8 or more after the shift held a half-weight carry; remove it.
  function automatic logic [WW-1:0] dabble(input logic [WW-1:0] w);
    logic [WW-1:0] r;
    logic [3:0]    d;
    r = w;
    for (int i = 0; i < DIGITS; i++) begin
      d = w[4*i +: 4];
      if (d >= 4'd8) begin
        r[4*i +: 4] = d - 4'd3;
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  function automatic logic has_bad_digit(input logic [WW-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  // One combined right shift of {work, accumulator} followed by per-digit correction.
  always_comb begin
    shift_d = {1'b0, work_q, acc_q[BW-1:1]};
    work_d  = dabble(shift_d[WW+BW-1:BW]);
    acc_d   = shift_d[BW-1:0];
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      work_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            work_q  <= bus.bcd_in;
            acc_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          if (has_bad_digit(work_q)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q   <= CW'(BW);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          acc_q  <= acc_d;
          cnt_q  <= cnt_q - CW'(1);
          // Counter still holds the pre-decrement value: 1 means this is the last shift.
          if (cnt_q == CW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            state_q <= SHIFT;
          end
        end
        DONE: begin
          if (!err_q) begin
            bin_out_q <= acc_q;
          end else begin
            bin_out_q <= bin_out_q;
          end
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.bin_out = bin_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 Parameter DIGITS, default 3: number of packed BCD digits at the input.
REQ-002 Parameter BW, default 10: binary output width; the configuration SHALL satisfy 2^BW > 10^DIGITS - 1.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  conversion request; sampled only in IDLE.
REQ-006 bcd_in  input  4*DIGITS  packed BCD {..., hundreds, tens, units}; units in [3:0].
REQ-007 bin_out  output  BW  registered binary result of the last successful conversion.
REQ-008 busy  output  1  high in LOAD and SHIFT states.
REQ-009 done  output  1  one-cycle pulse marking conversion end (success or error).
REQ-010 err  output  1  registered; high when the last accepted request held a digit greater than 9.

Function
REQ-011 FSM states SHALL be IDLE, LOAD, SHIFT and DONE, with no other reachable state.
REQ-012 IDLE: start=1 SHALL capture bcd_in into a DIGITS*4-bit work register, clear the BW-bit accumulator, clear err, and enter LOAD.
REQ-013 LOAD: if any captured digit > 9, set err=1 and go to DONE; otherwise load the iteration counter with BW and go to SHIFT.
REQ-014 SHIFT, each cycle: shift {work, accumulator} right by one bit as one register, so the work LSB enters the accumulator MSB.
REQ-015 SHIFT, same cycle, after the shift: every 4-bit work digit with value >= 8 SHALL have 3 subtracted (reverse double-dabble); the counter decrements.
REQ-016 After exactly BW SHIFT cycles, go to DONE; the work register is then all zeros for any valid input.
REQ-017 DONE: assert done=1 for exactly one cycle and return to IDLE.
REQ-018 DONE on success: load bin_out with the accumulator in the same cycle done is high.
REQ-019 DONE on error: leave bin_out unchanged.
REQ-020 Latency: start sampled at edge N gives done high in the cycle after edge N+BW+2 on success, and after edge N+2 on error.
REQ-021 start while busy or in DONE SHALL be ignored; requests are not queued.
REQ-022 bcd_in SHALL be sampled only at acceptance; later changes do not affect the running conversion.
REQ-023 start held high continuously SHALL start a new conversion on each return to IDLE, one idle cycle between conversions.
REQ-024 busy and done SHALL be decoded from the state register (Moore outputs), with no combinational path from start.
REQ-025 All arithmetic SHALL be unsigned; digit subtraction operates on 4 bits only and never borrows across digit boundaries.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, bin_out=0, err=0, done=0, busy=0, and clear the work register, accumulator and counter.
REQ-027 Reset asserted mid-conversion SHALL abort it with no done pulse, and bin_out SHALL read 0.
REQ-028 After rst_n deasserts, start SHALL be accepted on the first rising edge.

Verification
REQ-029 Reset then start with bcd_in=0x000 -> done after BW+2 cycles, bin_out=0, err=0.
REQ-030 bcd_in=0x999 -> bin_out=999 (0x3E7); bcd_in=0x255 -> bin_out=255; bcd_in=0x010 -> bin_out=10; err=0 for all three.
REQ-031 bcd_in=0x1A3 after a prior result of 255 -> done 2 cycles after start, err=1, bin_out stays 255.
REQ-032 Pulse start with 0x123, then pulse start with 0x456 during SHIFT -> single done, bin_out=123, second request dropped.
REQ-033 rst_n low during the 5th SHIFT cycle -> busy=0, bin_out=0 at once, no done; a fresh start with 0x042 -> bin_out=42.
REQ-034 Exhaustive sweep of 0x000-0x999 with valid digits -> bin_out equals the decimal value for every input, and busy is high for exactly BW+1 cycles per conversion.
